pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised fetch-address generator for the single-issue core; replaces the fixed 32-bit program counter at the front of the fetch stage. It holds IP, advances by 4 per accepted fetch, and stalls on control-flow opcodes until the execute stage resolves them. Redirects go to an absolute target. It adds a pipeline hold, a resolution timeout and optional misaligned-target trapping, and drives instruction memory and the link-address path.

## Interface
Parameters:
- XLEN, 32: address width in bits; must be at least 8.
- RESET_VEC, 0: IP value after reset, XLEN bits.
- TRAP_VEC, 32'h100: redirect address for a misaligned target (used only with the macro).
- MAX_WAIT, 8: maximum cycles spent in WAIT before timeout; must be at least 1.

Ports:
- CLK  in  1  core clock; all state updates on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- OP  in  7  opcode of the instruction currently fetched at IP.
- HOLD  in  1  downstream back-pressure; freezes IP while in RUN.
- BR_VALID  in  1  execute stage reports a resolved control-flow instruction.
- BR_TAKEN  in  1  resolution outcome; sampled only with BR_VALID.
- BR_TARGET  in  XLEN  absolute redirect address; sampled only with BR_VALID and BR_TAKEN.
- IP  out  XLEN  current fetch address (registered).
- PC_DEF  out  XLEN  IP+4, combinational, wraps mod 2^XLEN.
- FETCH_VALID  out  1  instruction at IP may issue this cycle.
- TIMEOUT  out  1  one-cycle pulse when WAIT expires.
- MISALIGN  out  1  one-cycle pulse on a trapped misaligned target.

## Operation
- Control-flow opcodes (cf): 7'b1101111 JAL, 7'b1100111 JALR, 7'b1100011 BRANCH.
- States: RUN, WAIT. A 2-bit state encoding is sufficient.
- Wait counter `wcnt`: width $clog2(MAX_WAIT+1).
- FETCH_VALID = (state==RUN) && !HOLD.
- RUN, HOLD=1: IP holds. The state stays RUN. cf detection is suppressed.
- RUN, HOLD=0, OP not cf: IP <= IP+4.
- RUN, HOLD=0, OP cf: IP holds, wcnt <= 0, next state WAIT. IP continues to address the cf instruction.
- WAIT, BR_VALID=1, BR_TAKEN=1: IP <= BR_TARGET. Next state RUN.
- WAIT, BR_VALID=1, BR_TAKEN=0: IP <= IP+4. Next state RUN.
- WAIT, BR_VALID=0, wcnt==MAX_WAIT-1: IP <= IP+4 (not-taken fallback), TIMEOUT=1 for that cycle, next state RUN.
- WAIT, otherwise: wcnt increments and IP holds.
- In WAIT, HOLD is ignored: resolution is always accepted.
- BR_VALID in RUN is ignored and has no side effect.
- If BR_VALID and the timeout condition coincide, BR_VALID wins and TIMEOUT stays 0.
- Arithmetic: all adds are XLEN-bit, unsigned, with carry discarded. IP = 2^XLEN-4 advances to 0.

## Timing
- Reset values: IP = RESET_VEC, state = RUN, wcnt = 0, TIMEOUT = 0, MISALIGN = 0. PC_DEF = RESET_VEC+4 and FETCH_VALID = !HOLD, both combinational.
- Reset mid-WAIT aborts the wait with no TIMEOUT pulse.
- After RESET_N deasserts, the first IP update is on the first rising CLK edge.
- Non-cf throughput: one address per cycle.
- cf cost: one cycle to enter WAIT, plus N cycles until BR_VALID (N ≥ 0), plus one redirect edge. Minimum cf bubble: 1 cycle, when BR_VALID arrives in the first WAIT cycle.
- BR_VALID, BR_TAKEN and BR_TARGET are sampled on the same edge. No combinational path runs from them to IP.
- TIMEOUT and MISALIGN are registered pulses and go high in the cycle after the deciding edge.

## Configuration
- With PC_MISALIGN_TRAP_EN defined: a taken resolution with BR_TARGET[1:0] != 0 sets IP <= TRAP_VEC and pulses MISALIGN for one cycle. The state goes to RUN.
- Without PC_MISALIGN_TRAP_EN: IP <= {BR_TARGET[XLEN-1:2], 2'b00}, MISALIGN is tied to 0, and TRAP_VEC is unused.

## Structure
- Shared package `pc_pkg`: opcode localparams (OP_JAL, OP_JALR, OP_BRANCH) and the state enum `pc_state_e {PC_RUN, PC_WAIT}`.
- The same package also holds function `is_cf(op)`, which the decoder reuses.
- One sub-module, `pc_wait_timer`: the wait counter with clear/enable inputs and an `expire` output.
- The top level holds the FSM, the IP register and the target mux.

## Test plan
- Reset: RESET_N low mid-run, RESET_VEC=32'h80 -> IP=0x80 and PC_DEF=0x84 asynchronously; FETCH_VALID=1 once HOLD=0.
- Sequential: 4 non-cf OPs -> IP goes 0x80, 0x84, 0x88, 0x8C, 0x90; raising HOLD for 2 cycles freezes IP at 0x90 with FETCH_VALID=0.
- Branch taken: OP=1100011 at 0x90, BR_VALID+BR_TAKEN with BR_TARGET=0x200 on the 3rd WAIT cycle -> IP stays 0x90 for 3 cycles, then becomes 0x200.
- Not taken and timeout: JALR at 0x40 with BR_TAKEN=0 -> IP goes to 0x44. Then with MAX_WAIT=8 and no BR_VALID -> TIMEOUT pulses once and IP advances by 4 after 8 WAIT cycles.
- Wrap and misalignment: IP=0xFFFFFFFC advancing -> IP=0. A taken target of 0x203 gives IP=TRAP_VEC with a MISALIGN pulse when the macro is defined, and IP=0x200 when it is not.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared fetch-front definitions: control-flow opcodes, PC FSM states and the
// control-flow classifier that the decoder also uses.
package pc_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        PC_RUN  = 2'd0,
        PC_WAIT = 2'd1
    } pc_state_e;

    function automatic logic is_cf(input logic [6:0] op);
        return (op == OP_JAL) || (op == OP_JALR) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/pc_wait_timer.sv
// Counts cycles spent waiting for branch resolution; o_expire flags the last
// allowed WAIT cycle (count == MAX_WAIT-1).
module pc_wait_timer #(
    parameter int MAX_WAIT = 8
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    logic [CW-1:0] r_wcnt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            r_wcnt <= '0;
        else if (i_clr)
            r_wcnt <= '0;
        else if (i_en)
            r_wcnt <= r_wcnt + CW'(1);
    end

    assign o_expire = (r_wcnt == LAST);

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: advances IP by 4, parks on control-flow opcodes until
// the execute stage resolves them or the wait times out. Define
// PC_MISALIGN_TRAP_EN to redirect misaligned taken targets to TRAP_VEC.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h100),
    parameter int              MAX_WAIT  = 8
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic [6:0]      OP,
    input  logic            HOLD,
    input  logic            BR_VALID,
    input  logic            BR_TAKEN,
    input  logic [XLEN-1:0] BR_TARGET,
    output logic [XLEN-1:0] IP,
    output logic [XLEN-1:0] PC_DEF,
    output logic            FETCH_VALID,
    output logic            TIMEOUT,
    output logic            MISALIGN
);

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    pc_state_e       r_state, w_state_nxt;
    logic [XLEN-1:0] r_ip, w_ip_nxt, w_ip_inc;
    logic            r_timeout, r_misalign;
    logic            w_timeout_nxt, w_misalign_nxt;
    logic            w_clr, w_en, w_expire, w_tgt_misal;

    pc_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .i_clr    (w_clr),
        .i_en     (w_en),
        .o_expire (w_expire)
    );

    assign w_ip_inc    = r_ip + XLEN'(4);
    assign w_tgt_misal = |BR_TARGET[1:0];

    always_comb begin
        w_state_nxt    = r_state;
        w_ip_nxt       = r_ip;
        w_timeout_nxt  = 1'b0;
        w_misalign_nxt = 1'b0;
        w_clr          = 1'b0;
        w_en           = 1'b0;
        case (r_state)
            PC_RUN: begin
                if (!HOLD) begin
                    if (is_cf(OP)) begin
                        w_clr       = 1'b1;
                        w_state_nxt = PC_WAIT;
                    end else begin
                        w_ip_nxt = w_ip_inc;
                    end
                end
            end
            PC_WAIT: begin
                // Resolution has priority over the timeout fallback.
                if (BR_VALID) begin
                    w_state_nxt = PC_RUN;
                    if (!BR_TAKEN) begin
                        w_ip_nxt = w_ip_inc;
                    end else if (TRAP_EN && w_tgt_misal) begin
                        w_ip_nxt       = TRAP_VEC;
                        w_misalign_nxt = 1'b1;
                    end else begin
                        w_ip_nxt = BR_TARGET & ~XLEN'(3);
                    end
                end else if (w_expire) begin
                    w_ip_nxt      = w_ip_inc;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = PC_RUN;
                end else begin
                    w_en = 1'b1;
                end
            end
            default: w_state_nxt = PC_RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= PC_RUN;
            r_ip       <= RESET_VEC;
            r_timeout  <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ip       <= w_ip_nxt;
            r_timeout  <= w_timeout_nxt;
            r_misalign <= w_misalign_nxt;
        end
    end

    assign IP          = r_ip;
    assign PC_DEF      = w_ip_inc;
    assign FETCH_VALID = (r_state == PC_RUN) && !HOLD;
    assign TIMEOUT     = r_timeout;
    assign MISALIGN    = r_misalign;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: the driver queues the expected outputs for each
// cycle, a negedge monitor pops and compares them.
module tb_pc_gen;

    localparam int XLEN = 32;
    localparam logic [6:0] NOP  = 7'b0010011;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;

`ifdef PC_MISALIGN_TRAP_EN
    localparam logic [31:0] MIS_IP  = 32'h100;
    localparam logic        MIS_PLS = 1'b1;
`else
    localparam logic [31:0] MIS_IP  = 32'h200;
    localparam logic        MIS_PLS = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] ip;
        logic [31:0] pc_def;
        logic        fv;
        logic        to;
        logic        mis;
    } exp_t;

    logic            CLK = 1'b0;
    logic            RESET_N = 1'b0;
    logic [6:0]      OP = NOP;
    logic            HOLD = 1'b0;
    logic            BR_VALID = 1'b0;
    logic            BR_TAKEN = 1'b0;
    logic [XLEN-1:0] BR_TARGET = '0;
    logic [XLEN-1:0] IP, PC_DEF;
    logic            FETCH_VALID, TIMEOUT, MISALIGN;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    pc_gen #(
        .XLEN(XLEN), .RESET_VEC(32'h80), .TRAP_VEC(32'h100), .MAX_WAIT(8)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .OP(OP), .HOLD(HOLD),
        .BR_VALID(BR_VALID), .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET),
        .IP(IP), .PC_DEF(PC_DEF), .FETCH_VALID(FETCH_VALID),
        .TIMEOUT(TIMEOUT), .MISALIGN(MISALIGN)
    );

    always #5 CLK = ~CLK;

    // Drive one cycle of inputs, queue the outputs expected during that cycle.
    task automatic cyc(input logic [6:0] op, input logic hold, input logic bv,
                       input logic bt, input logic [31:0] tgt,
                       input logic [31:0] e_ip, input logic e_fv,
                       input logic e_to, input logic e_mis);
        exp_t e;
        OP = op; HOLD = hold; BR_VALID = bv; BR_TAKEN = bt; BR_TARGET = tgt;
        e.ip = e_ip; e.pc_def = e_ip + 32'd4; e.fv = e_fv; e.to = e_to; e.mis = e_mis;
        q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if (IP !== e.ip || PC_DEF !== e.pc_def || FETCH_VALID !== e.fv ||
                TIMEOUT !== e.to || MISALIGN !== e.mis) begin
                n_err++;
                $display("FAIL cycle%0d: got ip=%h pcdef=%h fv=%b to=%b mis=%b, want ip=%h pcdef=%h fv=%b to=%b mis=%b",
                         n_cmp, IP, PC_DEF, FETCH_VALID, TIMEOUT, MISALIGN,
                         e.ip, e.pc_def, e.fv, e.to, e.mis);
            end
        end
    end

    initial begin
        @(posedge CLK); #1;
        // reset state, FETCH_VALID follows HOLD
        cyc(NOP, 0, 0, 0, 0, 32'h80, 1, 0, 0);
        cyc(NOP, 1, 0, 0, 0, 32'h80, 0, 0, 0);
        RESET_N = 1'b1;
        // sequential advance and HOLD freeze (HOLD also masks cf)
        cyc(NOP, 0, 0, 0, 0, 32'h80, 1, 0, 0);
        cyc(NOP, 0, 0, 0, 0, 32'h84, 1, 0, 0);
        cyc(NOP, 0, 0, 0, 0, 32'h88, 1, 0, 0);
        cyc(NOP, 0, 0, 0, 0, 32'h8C, 1, 0, 0);
        cyc(NOP, 1, 0, 0, 0, 32'h90, 0, 0, 0);
        cyc(NOP, 1, 0, 0, 0, 32'h90, 0, 0, 0);
        cyc(BR,  1, 0, 0, 0, 32'h90, 0, 0, 0);
        // taken branch resolved on the 3rd WAIT cycle
        cyc(BR,  0, 0, 0, 0, 32'h90, 1, 0, 0);
        cyc(NOP, 0, 0, 0, 0, 32'h90, 0, 0, 0);
        cyc(NOP, 0, 0, 0, 0, 32'h90, 0, 0, 0);
        cyc(NOP, 0, 1, 1, 32'h200, 32'h90, 0, 0, 0);
        // BR_VALID in RUN is ignored
        cyc(NOP, 0, 1, 1, 32'h999, 32'h200, 1, 0, 0);
        // minimum bubble: JAL resolved in first WAIT cycle
        cyc(JAL, 0, 0, 0, 0, 32'h204, 1, 0, 0);
        cyc(NOP, 0, 1, 1, 32'h40, 32'h204, 0, 0, 0);
        // JALR not taken
        cyc(JALR, 0, 0, 0, 0, 32'h40, 1, 0, 0);
        cyc(NOP, 0, 1, 0, 32'h300, 32'h40, 0, 0, 0);
        // timeout after 8 WAIT cycles, HOLD ignored in WAIT
        cyc(BR,  0, 0, 0, 0, 32'h44, 1, 0, 0);
        for (int i = 0; i < 8; i++)
            cyc(NOP, i[0], 0, 0, 0, 32'h44, 0, 0, 0);
        cyc(NOP, 0, 0, 0, 0, 32'h48, 1, 1, 0);
        cyc(NOP, 0, 0, 0, 0, 32'h4C, 1, 0, 0);
        // BR_VALID coinciding with timeout wins, no TIMEOUT
        cyc(BR,  0, 0, 0, 0, 32'h50, 1, 0, 0);
        for (int i = 0; i < 7; i++)
            cyc(NOP, 0, 0, 0, 0, 32'h50, 0, 0, 0);
        cyc(NOP, 0, 1, 1, 32'h500, 32'h50, 0, 0, 0);
        // wrap at top of address space
        cyc(JAL, 0, 0, 0, 0, 32'h500, 1, 0, 0);
        cyc(NOP, 0, 1, 1, 32'hFFFF_FFFC, 32'h500, 0, 0, 0);
        cyc(NOP, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 0, 0);
        // misaligned taken target
        cyc(BR,  0, 0, 0, 0, 32'h0, 1, 0, 0);
        cyc(NOP, 0, 1, 1, 32'h203, 32'h0, 0, 0, 0);
        cyc(NOP, 0, 0, 0, 0, MIS_IP, 1, 0, MIS_PLS);
        cyc(NOP, 0, 0, 0, 0, MIS_IP + 32'd4, 1, 0, 0);
        // reset mid-WAIT aborts with no TIMEOUT
        cyc(BR,  0, 0, 0, 0, MIS_IP + 32'd8, 1, 0, 0);
        cyc(NOP, 0, 0, 0, 0, MIS_IP + 32'd8, 0, 0, 0);
        RESET_N = 1'b0;
        cyc(NOP, 0, 0, 0, 0, 32'h80, 1, 0, 0);
        RESET_N = 1'b1;
        cyc(NOP, 0, 0, 0, 0, 32'h80, 1, 0, 0);
        cyc(NOP, 0, 0, 0, 0, 32'h84, 1, 0, 0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge CLK);
        if (q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
